// File: rtl/keycode_pio_arbiter.sv
// -----------------------------------------------------------------------------
// keycode_pio_arbiter
//
// Purpose:
//   Shares the 8-bit keycode PIO slave between two keycode producers, for
//   example the NIOS/USB path and a hardware replay/test source. It acts as an
//   Avalon-MM master on the PIO.
//   - Requesters are arbitrated round-robin.
//   - Every accepted keycode becomes exactly one single-cycle PIO write.
//   - When VERIFY=1, a single-cycle read-back follows each write. A read-back
//     mismatch sets a sticky error flag.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req0_valid/keycode/ready      requester 0 handshake; ready is combinational
//                                 and is only asserted in IDLE for the grantee
//   req1_valid/keycode/ready      requester 1 handshake
//   m_address                     PIO address (always 0)
//   m_chipselect, m_write_n       registered PIO strobes
//   m_writedata                   registered {zeros, keycode}
//   m_readdata                    PIO readdata, combinational from the slave
//   err_clear                     clears the sticky error flag (set wins)
//   busy                          high whenever the FSM is not in IDLE
//   err                           sticky read-back mismatch flag
//   grant_id                      requester of the most recent accepted transfer
//   last_keycode                  keycode most recently written to the PIO
// -----------------------------------------------------------------------------
module keycode_pio_arbiter #(
    parameter int KEY_W  = 8,
    parameter int DATA_W = 32,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [KEY_W-1:0]  req0_keycode,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [KEY_W-1:0]  req1_keycode,
    output logic              req1_ready,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              err_clear,
    output logic              busy,
    output logic              err,
    output logic              grant_id,
    output logic [KEY_W-1:0]  last_keycode
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // Read-back check. Any difference in the full word counts as a mismatch:
    // either a wrong keycode in the low bits or any set bit in the upper bits.
    function automatic logic readback_mismatch(
        input logic [DATA_W-1:0] rdata,
        input logic [KEY_W-1:0]  key
    );
        logic [DATA_W-1:0] expect_v;
        expect_v = {{(DATA_W-KEY_W){1'b0}}, key};
        return (rdata != expect_v);
    endfunction

    state_t             state_r;
    logic [KEY_W-1:0]   key_r;
    logic               rr_r;          // requester favoured when both are valid
    logic               grant_id_r;
    logic [KEY_W-1:0]   last_keycode_r;
    logic               err_r;
    logic               busy_r;
    logic               cs_r;
    logic               write_n_r;
    logic [DATA_W-1:0]  writedata_r;

    logic               grant_valid_s;
    logic               grant_sel_s;
    logic [KEY_W-1:0]   grant_key_s;
    logic               mismatch_s;

    // Round-robin grant selection; grants are only offered while IDLE.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_sel_s   = rr_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_sel_s   = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_sel_s   = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_sel_s   = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_sel_s   = 1'b0;
        end
    end

    // Keycode of the granted requester.
    always_comb begin
        if (grant_sel_s) begin
            grant_key_s = req1_keycode;
        end else begin
            grant_key_s = req0_keycode;
        end
    end

    // Read-back comparison, only meaningful during the READ cycle.
    always_comb begin
        if (state_r == ST_READ) begin
            mismatch_s = readback_mismatch(m_readdata, key_r);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    assign req0_ready = grant_valid_s & ~grant_sel_s;
    assign req1_ready = grant_valid_s &  grant_sel_s;

    // Main FSM. Bus strobes and busy are loaded for the state being entered,
    // so they line up with the state without any combinational output path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            key_r          <= {KEY_W{1'b0}};
            rr_r           <= 1'b0;
            grant_id_r     <= 1'b0;
            last_keycode_r <= {KEY_W{1'b0}};
            busy_r         <= 1'b0;
            cs_r           <= 1'b0;
            write_n_r      <= 1'b1;
            writedata_r    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        state_r     <= ST_WRITE;
                        key_r       <= grant_key_s;
                        grant_id_r  <= grant_sel_s;
                        rr_r        <= ~grant_sel_s;
                        busy_r      <= 1'b1;
                        cs_r        <= 1'b1;
                        write_n_r   <= 1'b0;
                        writedata_r <= {{(DATA_W-KEY_W){1'b0}}, grant_key_s};
                    end else begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        cs_r        <= 1'b0;
                        write_n_r   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    last_keycode_r <= key_r;
                    write_n_r      <= 1'b1;
                    if (VERIFY) begin
                        state_r <= ST_READ;
                        busy_r  <= 1'b1;
                        cs_r    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cs_r    <= 1'b0;
                    end
                end
                ST_READ: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    cs_r      <= 1'b0;
                    write_n_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    cs_r      <= 1'b0;
                    write_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Sticky error flag: a new mismatch takes priority over err_clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (mismatch_s) begin
            err_r <= 1'b1;
        end else if (err_clear) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign m_address    = 2'b00;
    assign m_chipselect = cs_r;
    assign m_write_n    = write_n_r;
    assign m_writedata  = writedata_r;
    assign busy         = busy_r;
    assign err          = err_r;
    assign grant_id     = grant_id_r;
    assign last_keycode = last_keycode_r;

endmodule

// File: tb/tb_keycode_pio_arbiter.sv
module tb_keycode_pio_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A: VERIFY=1
    logic        a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
    logic [7:0]  a_req0_keycode, a_req1_keycode, a_last;
    logic [1:0]  a_addr;
    logic        a_cs, a_wn, a_err_clear, a_busy, a_err, a_gid;
    logic [31:0] a_wdata, a_rdata;

    // Instance B: VERIFY=0
    logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [7:0]  b_req0_keycode, b_req1_keycode, b_last;
    logic [1:0]  b_addr;
    logic        b_cs, b_wn, b_err_clear, b_busy, b_err, b_gid;
    logic [31:0] b_wdata, b_rdata;

    // PIO slave models
    logic [7:0]  pio_a = 8'h00;
    logic [7:0]  pio_b = 8'h00;
    logic        rd_force;
    logic [31:0] rd_force_val;
    always @(posedge clk) if (a_cs && !a_wn) pio_a <= a_wdata[7:0];
    always @(posedge clk) if (b_cs && !b_wn) pio_b <= b_wdata[7:0];
    assign a_rdata = rd_force ? rd_force_val : {24'd0, pio_a};
    assign b_rdata = {24'd0, pio_b};

    keycode_pio_arbiter #(.KEY_W(8), .DATA_W(32), .VERIFY(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(a_req0_valid), .req0_keycode(a_req0_keycode), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_keycode(a_req1_keycode), .req1_ready(a_req1_ready),
        .m_address(a_addr), .m_chipselect(a_cs), .m_write_n(a_wn),
        .m_writedata(a_wdata), .m_readdata(a_rdata), .err_clear(a_err_clear),
        .busy(a_busy), .err(a_err), .grant_id(a_gid), .last_keycode(a_last)
    );

    keycode_pio_arbiter #(.KEY_W(8), .DATA_W(32), .VERIFY(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(b_req0_valid), .req0_keycode(b_req0_keycode), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_keycode(b_req1_keycode), .req1_ready(b_req1_ready),
        .m_address(b_addr), .m_chipselect(b_cs), .m_write_n(b_wn),
        .m_writedata(b_wdata), .m_readdata(b_rdata), .err_clear(b_err_clear),
        .busy(b_busy), .err(b_err), .grant_id(b_gid), .last_keycode(b_last)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a_reads = 0;
    int b_reads = 0;
    int b_writes = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: every write cycle pops the next expected writedata.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (a_cs && !a_wn) begin
            exp_v = (q_a.size() != 0) ? q_a.pop_front() : 32'hDEAD_BEEF;
            chk("a_write_data", a_wdata, exp_v);
            chk("a_write_addr", {30'd0, a_addr}, 32'd0);
        end
        if (a_cs && a_wn) a_reads++;
        if (b_cs && !b_wn) begin
            exp_v = (q_b.size() != 0) ? q_b.pop_front() : 32'hDEAD_BEEF;
            chk("b_write_data", b_wdata, exp_v);
            b_writes++;
        end
        if (b_cs && b_wn) b_reads++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   prev_wr;
        logic exp_g;
        reset_n = 1'b0;
        a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_req0_keycode = 8'h00; a_req1_keycode = 8'h00;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_keycode = 8'h00; b_req1_keycode = 8'h00;
        a_err_clear = 1'b0; b_err_clear = 1'b0;
        rd_force = 1'b0; rd_force_val = 32'h0;
        prev_wr = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_cs", {31'd0, a_cs}, 32'd0);
        chk("rst_wn", {31'd0, a_wn}, 32'd1);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_gid", {31'd0, a_gid}, 32'd0);
        chk("rst_last", {24'd0, a_last}, 32'd0);
        chk("rst_b_cs", {31'd0, b_cs}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single req0 transfer with read-back
        a_req0_valid = 1'b1; a_req0_keycode = 8'h1A; #1;
        chk("t1_ready0", {31'd0, a_req0_ready}, 32'd1);
        chk("t1_ready1", {31'd0, a_req1_ready}, 32'd0);
        q_a.push_back(32'h0000_001A);
        tick(); // WRITE
        a_req0_valid = 1'b0;
        chk("t1_wr_cs", {31'd0, a_cs}, 32'd1);
        chk("t1_wr_wn", {31'd0, a_wn}, 32'd0);
        chk("t1_wr_busy", {31'd0, a_busy}, 32'd1);
        chk("t1_wr_gid", {31'd0, a_gid}, 32'd0);
        chk("t1_wr_ready0", {31'd0, a_req0_ready}, 32'd0);
        tick(); // READ
        chk("t1_rd_cs", {31'd0, a_cs}, 32'd1);
        chk("t1_rd_wn", {31'd0, a_wn}, 32'd1);
        chk("t1_rd_busy", {31'd0, a_busy}, 32'd1);
        chk("t1_rd_last", {24'd0, a_last}, 32'h1A);
        tick(); // IDLE
        chk("t1_idle_busy", {31'd0, a_busy}, 32'd0);
        chk("t1_idle_cs", {31'd0, a_cs}, 32'd0);
        chk("t1_idle_wdata_hold", a_wdata, 32'h1A);
        chk("t1_err", {31'd0, a_err}, 32'd0);
        chk("t1_reads", a_reads, 32'd1);

        // Both valid continuously: alternate 0,1,0,1 from a fresh pointer
        reset_n = 1'b0; #1; reset_n = 1'b1;
        a_req0_keycode = 8'h04; a_req1_keycode = 8'h07;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0];
            chk("t2_ready0", {31'd0, a_req0_ready}, {31'd0, ~exp_g});
            chk("t2_ready1", {31'd0, a_req1_ready}, {31'd0, exp_g});
            q_a.push_back(exp_g ? 32'h07 : 32'h04);
            tick(); // WRITE
            chk("t2_gid", {31'd0, a_gid}, {31'd0, exp_g});
            if (i > 0) chk("t2_spacing", cyc - prev_wr, 32'd3);
            prev_wr = cyc;
            tick(); tick();
        end
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;

        // Read-back mismatch in the low bits
        rd_force = 1'b1; rd_force_val = 32'h0000_001B;
        a_req0_valid = 1'b1; a_req0_keycode = 8'h1A; #1;
        q_a.push_back(32'h1A);
        tick(); a_req0_valid = 1'b0;
        tick();
        chk("t3_err_before", {31'd0, a_err}, 32'd0);
        tick();
        chk("t3_err_set", {31'd0, a_err}, 32'd1);
        // Good write via req1 only: err stays set
        rd_force = 1'b0;
        a_req1_valid = 1'b1; a_req1_keycode = 8'h22; #1;
        chk("t3_ready1_only", {31'd0, a_req1_ready}, 32'd1);
        q_a.push_back(32'h22);
        tick(); a_req1_valid = 1'b0;
        chk("t3_gid1", {31'd0, a_gid}, 32'd1);
        tick(); tick();
        chk("t3_err_sticky", {31'd0, a_err}, 32'd1);
        chk("t3_last", {24'd0, a_last}, 32'h22);
        a_err_clear = 1'b1; tick(); a_err_clear = 1'b0;
        chk("t3_err_cleared", {31'd0, a_err}, 32'd0);
        // err_clear during the mismatching READ: set wins
        rd_force = 1'b1; rd_force_val = 32'h0000_001B;
        a_req0_valid = 1'b1; a_req0_keycode = 8'h1A; #1;
        q_a.push_back(32'h1A);
        tick(); a_req0_valid = 1'b0; a_err_clear = 1'b1;
        tick();
        tick(); a_err_clear = 1'b0;
        chk("t3_set_wins", {31'd0, a_err}, 32'd1);
        a_err_clear = 1'b1; tick(); a_err_clear = 1'b0;
        chk("t3_err_cleared2", {31'd0, a_err}, 32'd0);
        // Upper bits nonzero
        rd_force_val = 32'h0000_011A;
        a_req0_valid = 1'b1; a_req0_keycode = 8'h1A; #1;
        q_a.push_back(32'h1A);
        tick(); a_req0_valid = 1'b0;
        tick(); tick();
        chk("t4_upper_err", {31'd0, a_err}, 32'd1);
        rd_force = 1'b0;

        // VERIFY=0 instance: req1 streams 0x50..0x52
        b_req1_valid = 1'b1; b_req1_keycode = 8'h50; #1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_ready1", {31'd0, b_req1_ready}, 32'd1);
            chk("t5_ready0", {31'd0, b_req0_ready}, 32'd0);
            q_b.push_back(32'h50 + i);
            tick(); // WRITE
            chk("t5_busy", {31'd0, b_busy}, 32'd1);
            if (i > 0) chk("t5_spacing", cyc - prev_wr, 32'd2);
            prev_wr = cyc;
            if (i == 2) b_req1_valid = 1'b0;
            else b_req1_keycode = 8'h51 + i[7:0];
            tick(); // IDLE
            chk("t5_idle", {31'd0, b_busy}, 32'd0);
        end
        chk("t5_no_reads", b_reads, 32'd0);
        chk("t5_writes", b_writes, 32'd3);
        chk("t5_err", {31'd0, b_err}, 32'd0);
        chk("t5_last", {24'd0, b_last}, 32'h52);

        // Reset during WRITE
        a_req0_valid = 1'b1; a_req0_keycode = 8'h33; #1;
        tick(); // WRITE in flight
        chk("t6_in_write", {31'd0, a_cs}, 32'd1);
        a_req0_valid = 1'b0; a_req1_valid = 1'b1; a_req1_keycode = 8'h44;
        reset_n = 1'b0; #1;
        chk("t6_rst_cs", {31'd0, a_cs}, 32'd0);
        chk("t6_rst_wn", {31'd0, a_wn}, 32'd1);
        chk("t6_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("t6_rst_wdata", a_wdata, 32'd0);
        chk("t6_rst_last", {24'd0, a_last}, 32'd0);
        chk("t6_rst_err", {31'd0, a_err}, 32'd0);
        tick();
        reset_n = 1'b1; #1;
        chk("t6_req1_alone", {31'd0, a_req1_ready}, 32'd1);
        a_req0_valid = 1'b1; #1;
        chk("t6_ptr_req0", {31'd0, a_req0_ready}, 32'd1);
        chk("t6_ptr_not_req1", {31'd0, a_req1_ready}, 32'd0);
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        tick(); tick();

        chk("sb_a_empty", q_a.size(), 32'd0);
        chk("sb_b_empty", q_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keycode_pio_arbiter.md
Name: keycode_pio_arbiter

Overview:
- Avalon-MM master that shares the 8-bit keycode PIO slave (address 0, zero-wait-state, 32-bit readdata) between two keycode producers, e.g. the NIOS/USB path and a hardware replay/test source.
- Round-robin arbitration, one single-cycle PIO write per accepted keycode, optional read-back verification with a sticky error flag.
- Sits between the producers and the keycode PIO; the PIO out_port then feeds the game logic.

Parameters:
- KEY_W, 8, keycode width; writedata upper bits are zero.
- DATA_W, 32, Avalon data width.
- VERIFY, 1, 1 = read back and compare after every write; 0 = skip the READ state.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a keycode
- req0_keycode  in  KEY_W  requester 0 keycode
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid  in  1  requester 1 has a keycode
- req1_keycode  in  KEY_W  requester 1 keycode
- req1_ready  out  1  requester 1 transfer accepted this cycle
- m_address  out  2  PIO address, always 0 when chipselect is high
- m_chipselect  out  1  PIO chipselect
- m_write_n  out  1  PIO write strobe, active low
- m_writedata  out  DATA_W  {zeros, keycode}
- m_readdata  in  DATA_W  PIO readdata, combinational from the slave
- err_clear  in  1  clears the sticky error flag
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky read-back mismatch
- grant_id  out  1  requester of the most recent accepted transfer
- last_keycode  out  KEY_W  keycode most recently written to the PIO

Behaviour:
- Reset (async, reset_n=0): state=IDLE; m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0; busy=0, err=0, grant_id=0, last_keycode=0; RR pointer favours req0. An in-flight write or read is abandoned and no ready is issued.
- States: IDLE, WRITE, READ. READ is skipped when VERIFY=0.
- IDLE:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester that did not win the last grant (the first grant after reset goes to req0).
  - reqN_ready is combinational, asserted in IDLE only for the granted requester.
  - Transfer occurs on valid & ready. The keycode is captured into an internal register, grant_id and the RR pointer update, and the next state is WRITE.
  - No valid: stay in IDLE, all ready signals low.
- Requesters hold valid and keycode stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- WRITE (exactly 1 cycle): m_chipselect=1, m_write_n=0, m_address=0, m_writedata={zeros, key}. last_keycode<=key at the end of the cycle. Next state is READ if VERIFY=1, else IDLE.
- READ (exactly 1 cycle): m_chipselect=1, m_write_n=1, m_address=0. m_readdata is sampled at the closing clock edge.
  - Mismatch is m_readdata[KEY_W-1:0] != key, or any m_readdata[DATA_W-1:KEY_W] nonzero. A mismatch sets err.
  - Next state is IDLE.
- Bus outputs are registered. Outside WRITE/READ: chipselect=0, write_n=1, writedata holds its last value.
- Latency: accept at edge t, write cycle t+1, read cycle t+2 (VERIFY=1). The next accept is possible in the cycle after the last bus cycle. Throughput is 1 keycode per 3 cycles (VERIFY=1) or per 2 cycles (VERIFY=0).
- err: sticky until err_clear. If err_clear and a new mismatch occur in the same cycle, set wins (err=1).
- busy = (state != IDLE). Ready is never asserted while busy.
- Identical consecutive keycodes are still written; there is no dedup.

Test Plan:
- Reset, then req0_valid=1, key=0x1A -> req0_ready pulses 1 cycle. The next cycle shows chipselect=1, write_n=0, writedata=0x0000001A. Then a read cycle. err=0, last_keycode=0x1A, grant_id=0, busy high for 2 cycles.
- req0 and req1 both valid continuously, keys 0x04/0x07 -> grants alternate 0,1,0,1. Writes are spaced 3 cycles apart and writedata alternates 0x04/0x07.
- Bench slave returns readdata=0x0000001B for a 0x1A write -> err=1 after the READ cycle, stays 1 across later good writes, clears on err_clear. err_clear in the same cycle as a new mismatch -> err remains 1.
- Slave returns 0x0000011A for key 0x1A (upper bits nonzero) -> err=1.
- VERIFY=0, req1 streams 0x50,0x51,0x52 -> one write every 2 cycles, no read cycles, err stays 0.
- Assert reset_n=0 during WRITE -> outputs return to reset values immediately (write_n=1, chipselect=0). After release, a pending req1 is granted first only if req0 is idle (pointer favours req0).
